// File: rtl/fetch_sequencer_if.sv
// Fetch/issue bundle between the sequencer, instruction memory and datapath.
// master = sequencer side, slave = memory/datapath/control side.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 6
) ();
  logic                  start;
  logic                  stall;
  logic [15:0]           instruction;
  logic                  branch_ne;
  logic [ADDR_WIDTH-1:0] read_address;
  logic                  instr_valid;
  logic                  branch_pending;
  logic                  halted;
  logic [15:0]           retired_count;

  modport master (
    input  start, stall, instruction, branch_ne,
    output read_address, instr_valid, branch_pending, halted, retired_count
  );

  modport slave (
    output start, stall, instruction, branch_ne,
    input  read_address, instr_valid, branch_pending, halted, retired_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, issues one instruction per unstalled cycle,
// resolves BNE with one delay slot and halts after a run of NOOPs.
module fetch_sequencer #(
  parameter int         ADDR_WIDTH    = 6,
  parameter logic [3:0] OP_BNE        = 4'b1110,
  parameter logic [3:0] OP_NOOP       = 4'b0011,
  parameter int         NOOP_HALT_RUN = 4
) (
  input logic               clk,
  input logic               rst_n,
  fetch_sequencer_if.master bus
);

  localparam int CW = $clog2(NOOP_HALT_RUN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DELAY, HALT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] target;
  logic [CW-1:0]         noop_cnt;
  logic [15:0]           retired;
  logic                  halted_q;

  logic                  issue;
  logic [3:0]            opcode;
  logic                  is_noop;
  logic                  hits_halt;
  logic                  take_branch;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] branch_tgt;

  assign issue       = ((state == RUN) || (state == DELAY)) && !bus.stall;
  assign opcode      = bus.instruction[15:12];
  assign is_noop     = (opcode == OP_NOOP);
  assign hits_halt   = is_noop && (noop_cnt == CW'(NOOP_HALT_RUN - 1));
  // A BNE sitting in the delay slot is never taken.
  assign take_branch = (state == RUN) && (opcode == OP_BNE) && bus.branch_ne;
  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign offset      = {{(ADDR_WIDTH-4){bus.instruction[3]}}, bus.instruction[3:0]};
  assign branch_tgt  = pc_inc + offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      target   <= '0;
      noop_cnt <= '0;
      retired  <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (bus.start) begin
            state    <= RUN;
            pc       <= '0;
            noop_cnt <= '0;
            retired  <= '0;
            halted_q <= 1'b0;
          end
        end
        RUN, DELAY: begin
          if (issue) begin
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
            noop_cnt <= is_noop ? noop_cnt + CW'(1) : '0;
            // Halt wins over a pending branch target; PC keeps its post-increment value.
            if (hits_halt) begin
              state    <= HALT;
              pc       <= pc_inc;
              halted_q <= 1'b1;
            end else if (state == DELAY) begin
              state <= RUN;
              pc    <= target;
            end else begin
              pc <= pc_inc;
              if (take_branch) begin
                target <= branch_tgt;
                state  <= DELAY;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_address   = pc;
  assign bus.instr_valid    = issue;
  assign bus.branch_pending = (state == DELAY);
  assign bus.halted         = halted_q;
  assign bus.retired_count  = retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: program-level reference model checked every
// negedge, plus literal expectations at the key points of each scenario.
module tb_fetch_sequencer;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH(AW), .OP_BNE(4'b1110), .OP_NOOP(4'b0011), .NOOP_HALT_RUN(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [15:0] imem [64];
  logic        bne_tbl [64];

  assign bus.instruction = imem[bus.read_address];
  assign bus.branch_ne   = bne_tbl[bus.read_address];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Program-level model: a pending redirect queue stands for the delay slot.
  bit m_run, m_halt;
  int m_pc, m_noops, m_ret;
  int m_redir[$];

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_pc = 0; m_noops = 0; m_ret = 0;
    m_redir.delete();
  endtask

  task automatic model_step();
    logic [15:0] ins;
    int off;
    if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_halt = 0; m_pc = 0; m_noops = 0; m_ret = 0;
        m_redir.delete();
      end
    end else if (!bus.stall) begin
      ins = imem[m_pc];
      off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
      if (m_ret < 65535) m_ret++;
      m_noops = (ins[15:12] == 4'h3) ? m_noops + 1 : 0;
      if (m_noops == 4) begin
        m_run = 0; m_halt = 1; m_pc = (m_pc + 1) % 64;
        m_redir.delete();
      end else if (m_redir.size() > 0) begin
        m_pc = m_redir.pop_front();
      end else begin
        if (ins[15:12] == 4'hE && bne_tbl[m_pc])
          m_redir.push_back((m_pc + 1 + off + 64) % 64);
        m_pc = (m_pc + 1) % 64;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    if (chk_en) begin
      cmp("m_addr",    int'(bus.read_address),   m_pc);
      cmp("m_valid",   int'(bus.instr_valid),    int'(m_run && !bus.stall));
      cmp("m_pending", int'(bus.branch_pending), int'(m_run && m_redir.size() > 0));
      cmp("m_halted",  int'(bus.halted),         int'(m_halt));
      cmp("m_retired", int'(bus.retired_count),  m_ret);
    end
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_addr(input int a, input int budget);
    int n = 0;
    while (int'(bus.read_address) != a && n < budget) begin
      tick();
      n++;
    end
    cmp("wait_addr", int'(bus.read_address), a);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!bus.halted && n < budget) begin
      tick();
      n++;
    end
    cmp("wait_halt", int'(bus.halted), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    for (int i = 0; i < 64; i++) begin
      imem[i]    = 16'h1000;
      bne_tbl[i] = 1'b0;
    end
    imem[1] = 16'hE202; bne_tbl[1] = 1'b1;
    imem[6] = 16'hE27D; bne_tbl[6] = 1'b1;
    for (int i = 8; i < 12; i++) imem[i] = 16'h3000;
    model_reset();
    chk_en = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    cmp("rst_addr",   int'(bus.read_address), 0);
    cmp("rst_valid",  int'(bus.instr_valid), 0);
    cmp("rst_halted", int'(bus.halted), 0);

    pulse_start();
    cmp("start_addr",  int'(bus.read_address), 0);
    cmp("start_valid", int'(bus.instr_valid), 1);

    // Forward taken branch at 1 -> 2 (slot) -> 4
    tick(); cmp("fwd_bne", int'(bus.read_address), 1);
    tick(); cmp("fwd_slot", int'(bus.read_address), 2);
    cmp("fwd_pending", int'(bus.branch_pending), 1);
    tick(); cmp("fwd_tgt", int'(bus.read_address), 4);
    // Backward taken branch 6 -> 7 -> 4, then not taken 6 -> 7 -> 8
    tick(); tick(); cmp("bwd_bne", int'(bus.read_address), 6);
    tick(); cmp("bwd_slot", int'(bus.read_address), 7);
    tick(); cmp("bwd_tgt", int'(bus.read_address), 4);
    bne_tbl[6] = 1'b0;
    tick(); tick(); tick(); tick();
    cmp("nt_addr", int'(bus.read_address), 8);
    // NOOPs at 8..11 halt the program
    tick(); tick(); tick(); tick();
    cmp("halt_flag",    int'(bus.halted), 1);
    cmp("halt_addr",    int'(bus.read_address), 12);
    cmp("halt_valid",   int'(bus.instr_valid), 0);
    cmp("halt_retired", int'(bus.retired_count), 15);
    tick(); tick();
    cmp("halt_frozen", int'(bus.read_address), 12);

    pulse_start();
    cmp("restart_addr",    int'(bus.read_address), 0);
    cmp("restart_retired", int'(bus.retired_count), 0);
    cmp("restart_halted",  int'(bus.halted), 0);

    // Stall three cycles inside the delay slot
    tick(); tick();
    bus.stall = 1'b1;
    #1;
    cmp("stall_valid", int'(bus.instr_valid), 0);
    for (int i = 0; i < 3; i++) begin
      cmp("stall_addr",    int'(bus.read_address), 2);
      cmp("stall_pending", int'(bus.branch_pending), 1);
      cmp("stall_retired", int'(bus.retired_count), 2);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    cmp("unstall_valid", int'(bus.instr_valid), 1);
    tick();
    cmp("unstall_tgt",     int'(bus.read_address), 4);
    cmp("unstall_retired", int'(bus.retired_count), 3);
    wait_halt(20);
    cmp("halt2_retired", int'(bus.retired_count), 11);

    // Asynchronous reset while in the delay slot
    pulse_start();
    tick(); tick();
    cmp("pre_rst_pending", int'(bus.branch_pending), 1);
    rst_n = 1'b0;
    #1;
    cmp("arst_addr",    int'(bus.read_address), 0);
    cmp("arst_valid",   int'(bus.instr_valid), 0);
    cmp("arst_pending", int'(bus.branch_pending), 0);
    cmp("arst_retired", int'(bus.retired_count), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    cmp("idle_valid", int'(bus.instr_valid), 0);

    // Wrap 63 -> 0, then BNE at 63 with offset +1 lands on 1
    bne_tbl[1] = 1'b0;
    for (int i = 8; i < 12; i++) imem[i] = 16'h1000;
    pulse_start();
    wait_addr(63, 100);
    cmp("wrap_retired", int'(bus.retired_count), 63);
    tick(); cmp("wrap_addr", int'(bus.read_address), 0);
    imem[63] = 16'hE001; bne_tbl[63] = 1'b1;
    wait_addr(63, 100);
    tick(); cmp("wrap_slot", int'(bus.read_address), 0);
    cmp("wrap_pending", int'(bus.branch_pending), 1);
    tick(); cmp("wrap_tgt", int'(bus.read_address), 1);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
